shift_add_multiplier8: RTL and testbench

- Sequential 8x8 multiplier that drives the team's 8-bit ripple-carry adder (bit8carryadder) once per clock and consumes its sum and carry-out.
- Sits between operand entry (switch/register front end) and the product display/BCD stage.
- Accepts two 8-bit operands on a start pulse, runs 8 shift-add iterations and returns a registered 16-bit product with a done pulse.

---
 rtl/shift_add_multiplier8.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier8.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier8.sv
// Sequential 8x8 shift-add multiplier built around the shared ripple-carry adder.
// Works on operand magnitudes and applies the product sign in a final cycle.

module bit8carryadder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];
endmodule

module shift_add_multiplier8 #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [15:0] product_q, product_d;
    logic        done_q, done_d;

    logic [7:0]  a_mag, b_mag;
    logic [7:0]  add_b, add_sum;
    logic        add_cout;

    // The adder only ever sees the accumulator and either M or zero.
    assign add_b = q_q[0] ? m_q : 8'h00;

    bit8carryadder u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // -128 maps to 8'h80, which is the correct unsigned magnitude.
    assign a_mag = ((SIGNED != 1'b0) && a[7]) ? (~a + 8'd1) : a;
    assign b_mag = ((SIGNED != 1'b0) && b[7]) ? (~b + 8'd1) : b;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MUL;
                    m_d     = a_mag;
                    q_d     = b_mag;
                    acc_d   = 8'h00;
                    cnt_d   = 3'd0;
                    sign_d  = (SIGNED != 1'b0) ? (a[7] ^ b[7]) : 1'b0;
                end
            end
            MUL: begin
                // Right shift of {carry, sum, Q}; Q[0] has been consumed.
                {acc_d, q_d} = {add_cout, add_sum, q_q[7:1]};
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                product_d = sign_q ? (~{acc_q, q_q} + 16'd1) : {acc_q, q_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= 8'h00;
            q_q       <= 8'h00;
            acc_q     <= 8'h00;
            cnt_q     <= 3'd0;
            sign_q    <= 1'b0;
            product_q <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_shift_add_multiplier8.sv
// Directed bench: a signed and an unsigned multiplier share the same stimulus
// and are compared against hand-computed products.

module tb_shift_add_multiplier8;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic [15:0] prod_s, prod_u;
    logic        busy_s, busy_u;
    logic        done_s, done_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier8 #(.SIGNED(1'b1)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (prod_s),
        .busy    (busy_s),
        .done    (done_s)
    );

    shift_add_multiplier8 #(.SIGNED(1'b0)) dut_u (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (prod_u),
        .busy    (busy_u),
        .done    (done_u)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done_s; lat stays 0 if the bound expires.
    task automatic waitDone(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        if (busy_s) busy_cnt++;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_s) begin
                lat = i;
                break;
            end
            if (busy_s) busy_cnt++;
        end
    endtask

    task automatic runCheck(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] exp_s, input logic [15:0] exp_u);
        int lat, bc;
        applyStimulus(av, bv);
        waitDone(lat, bc);
        checkOutput({tag, " latency"}, lat, 9);
        checkOutput({tag, " signed"}, prod_s, exp_s);
        checkOutput({tag, " unsigned"}, prod_u, exp_u);
        checkOutput({tag, " done_u"}, done_u, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int lat, bc, seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset product", prod_s, 16'h0000);
        checkOutput("reset busy", busy_s, 1'b0);
        checkOutput("reset done", done_s, 1'b0);
        rst = 1'b0;

        $display("[TB] 13 x 11");
        applyStimulus(8'd13, 8'd11);
        waitDone(lat, bc);
        checkOutput("13x11 latency", lat, 9);
        checkOutput("13x11 busy cycles", bc, 9);
        checkOutput("13x11 busy in done", busy_s, 1'b0);
        checkOutput("13x11 product", prod_s, 16'h008F);
        checkOutput("13x11 product u", prod_u, 16'h008F);
        @(negedge clk);
        checkOutput("13x11 done drops", done_s, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("13x11 product holds", prod_s, 16'h008F);

        $display("[TB] signed mixes and extremes");
        runCheck("F9x06", 8'hF9, 8'h06, 16'hFFD6, 16'h05D6);
        runCheck("05xFB", 8'h05, 8'hFB, 16'hFFE7, 16'h04E7);
        runCheck("FDxFC", 8'hFD, 8'hFC, 16'h000C, 16'hF90C);
        runCheck("00xFB", 8'h00, 8'hFB, 16'h0000, 16'h0000);
        runCheck("80x80", 8'h80, 8'h80, 16'h4000, 16'h4000);
        runCheck("80x7F", 8'h80, 8'h7F, 16'hC080, 16'h3F80);
        runCheck("7Fx7F", 8'h7F, 8'h7F, 16'h3F01, 16'h3F01);
        runCheck("FFxFF", 8'hFF, 8'hFF, 16'h0001, 16'hFE01);
        runCheck("80x02", 8'h80, 8'h02, 16'hFF00, 16'h0100);

        $display("[TB] handshake");
        applyStimulus(8'd6, 8'd7);
        repeat (2) @(negedge clk);
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignored start busy", busy_s, 1'b1);
        waitDone(lat, bc);
        checkOutput("6x7 latency", lat, 6);
        checkOutput("6x7 product", prod_s, 16'h002A);
        a     = 8'd2;
        b     = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("back-to-back busy", busy_s, 1'b1);
        checkOutput("product held during op", prod_s, 16'h002A);
        waitDone(lat, bc);
        checkOutput("done-to-done spacing", lat + 1, 10);
        checkOutput("2x3 product", prod_s, 16'h0006);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        applyStimulus(8'd9, 8'd9);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", busy_s, 1'b0);
        checkOutput("abort done", done_s, 1'b0);
        checkOutput("abort product", prod_s, 16'h0000);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_s || done_u) seen++;
        end
        checkOutput("no done after abort", seen, 0);
        runCheck("9x9 after abort", 8'd9, 8'd9, 16'h0051, 16'h0051);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
